// File: rtl/fifo_sync_param_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package fifo_pkg;

    typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake bundle between a FIFO user (master) and the FIFO (slave).
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
);
    localparam int PW = ptr_w(DEPTH);

    logic              wren;
    logic [DATA_W-1:0] wdata;
    logic              rden;
    logic              clr_err;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [PW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wren, wdata, rden, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wren, wdata, rden, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_param_mem.sv
// FIFO storage: register array with synchronous write and asynchronous read.
module fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with fill count, threshold flags,
// sticky error flags and selectable standard / first-word-fall-through read.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic            clk,
    input  logic            arst,
    fifo_sync_param_if.slave bus
);

    localparam int         PW   = ptr_w(DEPTH);
    localparam int         AW   = PW - 1;
    localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [PW-1:0]     wrptr;
    logic [PW-1:0]     rdptr;
    logic [PW-1:0]     count;
    logic              full;
    logic              empty;
    logic              wr_acc;
    logic              rd_acc;
    logic              overflow;
    logic              underflow;
    logic [DATA_W-1:0] mem_rdata;

    // Flags come only from registered pointers, never from wren/rden.
    assign count  = wrptr - rdptr;
    assign empty  = (wrptr == rdptr);
    assign full   = (wrptr[AW-1:0] == rdptr[AW-1:0]) && (wrptr[AW] != rdptr[AW]);
    assign wr_acc = bus.wren && !full;
    assign rd_acc = bus.rden && !empty;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wrptr <= '0;
            rdptr <= '0;
        end else begin
            if (wr_acc) wrptr <= wrptr + 1'b1;
            if (rd_acc) rdptr <= rdptr + 1'b1;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.wren && full)       overflow  <= 1'b1;
            else if (bus.clr_err)       overflow  <= 1'b0;
            if (bus.rden && empty)      underflow <= 1'b1;
            else if (bus.clr_err)       underflow <= 1'b0;
        end
    end

    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wrptr[AW-1:0]),
        .wdata (bus.wdata),
        .raddr (rdptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            assign bus.rdata  = mem_rdata;
            assign bus.rvalid = !empty;
        end else begin : g_std
            logic [DATA_W-1:0] rdata_p1;
            logic              vld_p1;

            // Read stage: registered word, one-cycle valid pulse.
            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    rdata_p1 <= '0;
                    vld_p1   <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc) rdata_p1 <= mem_rdata;
                end
            end

            assign bus.rdata  = rdata_p1;
            assign bus.rvalid = vld_p1;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.count        = count;
    assign bus.almost_full  = (count >= PW'(AF_THRESH));
    assign bus.almost_empty = (count <= PW'(AE_THRESH));
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule
